// File: rtl/bitseq_looper_v3.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : bitseq_looper_v3
// Brief    : Multi-channel word-sequence looper. Each channel plays a private
//            pattern RAM at its own rate after a phase delay, independently
//            or via arm/group-start. Feature macro: BITSEQ_LOOP_COUNT_EN
//            (finite loop counts and done pulse; runs are infinite without it).
// Revision : 1.0 - initial release
// ============================================================================
module bitseq_looper_v3 #(
    parameter int NCH  = 4,
    parameter int AW   = 4,
    parameter int DW   = 1,
    parameter int DIVW = 32,
    parameter int LW   = 8,
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        start_ch_bus,
    input  logic [NCH-1:0]        stop_ch_bus,
    input  logic                  sync_enable,
    input  logic [NCH-1:0]        arm_mask_in,
    input  logic                  arm_load,
    input  logic                  group_start,
    input  logic [NCH*(AW+1)-1:0] len_bus,
    input  logic [NCH*DIVW-1:0]   rate_div_bus,
    input  logic [NCH*DIVW-1:0]   phase_off_bus,
    input  logic [NCH*LW-1:0]     loop_bus,
    input  logic [NCH*DW-1:0]     idle_bus,
    input  logic                  wr_en,
    input  logic [CW-1:0]         wr_ch,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DW-1:0]         wr_data,
    output logic [NCH*DW-1:0]     io_out,
    output logic [NCH-1:0]        playing,
    output logic [NCH-1:0]        armed,
    output logic [NCH-1:0]        done
);

    localparam int LENW  = AW + 1;
    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PHASE = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    logic [NCH-1:0] r_armed;
    logic [NCH-1:0] w_arm_base;
    logic [NCH-1:0] w_start;

    // A same-cycle arm_load feeds group_start directly with the new mask.
    assign w_arm_base = arm_load ? (arm_mask_in & ~playing) : r_armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed <= '0;
        end else begin
            r_armed <= w_arm_base & ~w_start & ~stop_ch_bus;
        end
    end

    assign armed = r_armed;

`ifndef BITSEQ_LOOP_COUNT_EN
    logic w_unused_loop;
    assign w_unused_loop = ^loop_bus;
    assign done          = '0;
`endif

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [DW-1:0]   r_mem [DEPTH];
        logic [1:0]      r_state, w_state_nx;
        logic [LENW-1:0] w_len_raw, w_len_in, r_len, w_len_nx;
        logic [DIVW-1:0] w_phase_in, r_rate, w_rate_nx, r_cnt, w_cnt_nx;
        logic [AW-1:0]   r_addr, w_addr_nx;
        logic [DW-1:0]   r_out, w_out_nx;
        logic            w_req;
`ifdef BITSEQ_LOOP_COUNT_EN
        logic [LW-1:0]   r_loops, w_loops_nx, r_lcnt, w_lcnt_nx;
        logic            r_done, w_done_nx;
`endif

        assign w_len_raw  = len_bus[k*LENW +: LENW];
        assign w_len_in   = (w_len_raw > LENW'(DEPTH)) ? LENW'(DEPTH) : w_len_raw;
        assign w_phase_in = phase_off_bus[k*DIVW +: DIVW];
        assign w_req      = sync_enable ? (group_start & w_arm_base[k]) : start_ch_bus[k];
        assign w_start[k] = w_req & ~stop_ch_bus[k] & (w_len_in != '0);

        // r_cnt counts phase clocks down in PHASE and word clocks up in RUN.
        always_comb begin
            w_state_nx = r_state;
            w_len_nx   = r_len;
            w_rate_nx  = r_rate;
            w_cnt_nx   = r_cnt;
            w_addr_nx  = r_addr;
`ifdef BITSEQ_LOOP_COUNT_EN
            w_loops_nx = r_loops;
            w_lcnt_nx  = r_lcnt;
            w_done_nx  = 1'b0;
`endif
            if (stop_ch_bus[k]) begin
                w_state_nx = S_IDLE;
            end else if (w_start[k]) begin
                w_len_nx   = w_len_in;
                w_rate_nx  = rate_div_bus[k*DIVW +: DIVW];
                w_cnt_nx   = w_phase_in;
                w_addr_nx  = '0;
                w_state_nx = (w_phase_in == '0) ? S_RUN : S_PHASE;
`ifdef BITSEQ_LOOP_COUNT_EN
                w_loops_nx = loop_bus[k*LW +: LW];
                w_lcnt_nx  = '0;
`endif
            end else begin
                case (r_state)
                    S_PHASE: begin
                        if (r_cnt == DIVW'(1)) begin
                            w_state_nx = S_RUN;
                            w_cnt_nx   = '0;
                            w_addr_nx  = '0;
                        end else begin
                            w_cnt_nx = r_cnt - DIVW'(1);
                        end
                    end
                    S_RUN: begin
                        if (r_cnt == r_rate) begin
                            w_cnt_nx = '0;
                            if ((LENW'(r_addr) + LENW'(1)) == r_len) begin
                                w_addr_nx = '0;
`ifdef BITSEQ_LOOP_COUNT_EN
                                w_lcnt_nx = r_lcnt + LW'(1);
                                if ((r_loops != '0) && (w_lcnt_nx == r_loops)) begin
                                    w_state_nx = S_IDLE;
                                    w_done_nx  = 1'b1;
                                end
`endif
                            end else begin
                                w_addr_nx = r_addr + AW'(1);
                            end
                        end else begin
                            w_cnt_nx = r_cnt + DIVW'(1);
                        end
                    end
                    S_IDLE:  ;
                    default: w_state_nx = S_IDLE;
                endcase
            end
            w_out_nx = (w_state_nx == S_RUN) ? r_mem[w_addr_nx] : idle_bus[k*DW +: DW];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= S_IDLE;
                r_len   <= '0;
                r_rate  <= '0;
                r_cnt   <= '0;
                r_addr  <= '0;
                r_out   <= '0;
`ifdef BITSEQ_LOOP_COUNT_EN
                r_loops <= '0;
                r_lcnt  <= '0;
                r_done  <= 1'b0;
`endif
            end else begin
                r_state <= w_state_nx;
                r_len   <= w_len_nx;
                r_rate  <= w_rate_nx;
                r_cnt   <= w_cnt_nx;
                r_addr  <= w_addr_nx;
                r_out   <= w_out_nx;
`ifdef BITSEQ_LOOP_COUNT_EN
                r_loops <= w_loops_nx;
                r_lcnt  <= w_lcnt_nx;
                r_done  <= w_done_nx;
`endif
            end
        end

        // Pattern RAM is not reset; writes are accepted only while the channel is idle.
        always_ff @(posedge clk) begin
            if (wr_en && (wr_ch == CW'(k)) && (r_state == S_IDLE)) begin
                r_mem[wr_addr] <= wr_data;
            end
        end

        assign io_out[k*DW +: DW] = r_out;
        assign playing[k]         = (r_state != S_IDLE);
`ifdef BITSEQ_LOOP_COUNT_EN
        assign done[k]            = r_done;
`endif
    end

endmodule
`default_nettype wire

// File: doc/bitseq_looper_v3.md
# bitseq_looper_v3

Multi-channel word-sequence looper: next generation of the bit-sequence looper. Each channel holds a private pattern RAM of `DW`-bit words, plays it cyclically at a per-channel rate after a per-channel phase delay, and stops after a programmed loop count or runs forever. Channels start independently or together via arm/group-start. The block sits between the host register bank (config buses, write port) and the debugger output pins.

## Interface
- `NCH`, 4: channel count (1..16).
- `AW`, 4: pattern address width; depth `2**AW` words per channel.
- `DW`, 1: word width per channel output (1 = bit mode).
- `DIVW`, 32: width of the rate divider and phase counters.
- `LW`, 8: loop-count width.
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous reset, active-high.
- `start_ch_bus`  in  NCH: per-channel start pulse (independent mode only).
- `stop_ch_bus`  in  NCH: per-channel stop pulse (both modes).
- `sync_enable`  in  1: 1 = sync mode.
- `arm_mask_in`  in  NCH: arm bitmap.
- `arm_load`  in  1: load `arm_mask_in` (1-cycle pulse).
- `group_start`  in  1: start all armed channels (1-cycle pulse).
- `len_bus`  in  NCH*(AW+1): packed length, channel k at `[k*(AW+1) +: AW+1]`.
- `rate_div_bus`  in  NCH*DIVW: word period minus 1, in clocks.
- `phase_off_bus`  in  NCH*DIVW: start delay in clocks.
- `loop_bus`  in  NCH*LW: loop count; 0 = infinite.
- `idle_bus`  in  NCH*DW: value driven while not playing.
- `wr_en`, `wr_ch`(clog2 NCH, min 1), `wr_addr`(AW), `wr_data`(DW)  in: pattern write port.
- `io_out`  out  NCH*DW: registered channel outputs.
- `playing`  out  NCH: channel in PHASE or RUN.
- `armed`  out  NCH: arm register.
- `done`  out  NCH: 1-cycle pulse at natural end of a finite run.

## Operation
- Per-channel FSM: IDLE, PHASE, RUN. ARMED is a flag (`armed[k]`) valid only in IDLE.
- Start event (independent: `start_ch_bus[k]` with `sync_enable`=0; sync: `group_start` with `armed[k]`=1) snapshots len, rate_div, phase_off, loops; go PHASE if phase_off>0 else RUN at word 0.
- `len`=0: start ignored, channel stays IDLE. `len`>`2**AW`: clamped to `2**AW`.
- PHASE: output idle value for exactly phase_off clocks, then RUN at word 0.
- RUN: each word held rate_div+1 clocks. After word len-1, address wraps to 0 and loop counter increments. When loops≠0 and the counter reaches loops, the channel goes IDLE and pulses `done`.
- Stop: any state → IDLE, clears `armed[k]`, no `done`. Stop and start in the same cycle: stop wins.
- Start while PHASE/RUN: retrigger with a fresh snapshot from word 0.
- `arm_load` sets `armed` to `arm_mask_in & ~playing`. `arm_load` and `group_start` in the same cycle: the new mask is used. `group_start` clears `armed` for the channels it starts.
- `start_ch_bus` is ignored when `sync_enable`=1. `group_start` is ignored when `sync_enable`=0.
- Writes land only if channel `wr_ch` is IDLE; otherwise they are dropped. `wr_ch`≥NCH is dropped.

## Timing
- Reset: `io_out`=0, `playing`=0, `armed`=0, `done`=0, all FSMs IDLE. RAM contents are not reset.
- Start sampled at edge N, phase_off=0: `io_out` = word0 and `playing`=1 from edge N+1. With phase_off=P: `playing`=1 from N+1, word0 from N+1+P.
- IDLE: `io_out` follows `idle_bus` with 1-clock latency.
- `done` is asserted at the edge where the final word's hold ends. The same edge: `playing`=0 and `io_out` = idle value.
- Stop at edge N: `playing`=0 and `io_out` = idle value from N+1.
- A write at edge N is visible to a start at edge N+1.
- Counters are unsigned DIVW-bit. rate_div=0 gives one word per clock.

## Configuration
- `BITSEQ_LOOP_COUNT_EN` defined: loop counter, `loop_bus`, and `done` behave as above.
- Undefined: every run is infinite, `loop_bus` is ignored, `done` is tied 0, and no loop counter logic is built.

## Test plan
- NCH=4, DW=1, ch0 len=10 pattern 1010101010, rate_div=49, start ch0 → `io_out[0]` toggles every 50 clocks from the edge after start; period is 500 clocks per sequence.
- Sync mode, four channels len=8, distinct patterns, arm_mask=4'hF, then group_start → all `playing` rise on the same edge, words are aligned across channels, `armed`=0 afterward.
- ch1 phase_off=30, ch2 phase_off=0, same group_start → ch1 word0 appears exactly 30 clocks after ch2 word0.
- DW=4, loops=3, len=4, rate_div=1 → 24 RUN clocks, then `done[0]` pulses once and `io_out` = idle_bus value (4'hA). With the macro undefined, the channel never stops.
- While ch0 plays, write addr0; start+stop same cycle; `len`=0 start → write dropped, channel IDLE, start ignored.
- Assert `rst` mid-RUN → all outputs 0 asynchronously; a restart after release replays the intact RAM.
